// File: rtl/demux_stream_n_pkg.sv
// Shared definitions for the N-way stream demultiplexer.
// Lock FSM encoding and drop counter width.
package demux_stream_n_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int DROP_CNT_BITS = 16;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register for one demux channel.
// The slot reloads in the same cycle it drains.
module demux_out_slot #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_last,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 last,
  output logic                 free
);

  assign free = !valid | ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      last  <= in_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_n.sv
// Registered N-way stream demux with packet lock and broadcast.
// Holds target decode, lock FSM, in_ready and the drop counter.
module demux_stream_n
  import demux_stream_n_pkg::*;
#(
  parameter  int DATA_BITS = 32,
  parameter  int N_OUT     = 4,
  localparam int SEL_BITS  = $clog2(N_OUT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic [SEL_BITS-1:0]        in_sel,
  input  logic                       in_bcast,
  input  logic                       in_last,
  output logic [N_OUT-1:0]           out_valid,
  input  logic [N_OUT-1:0]           out_ready,
  output logic [N_OUT*DATA_BITS-1:0] out_data,
  output logic [N_OUT-1:0]           out_last,
  output logic                       err_sel,
  output logic [DROP_CNT_BITS-1:0]   drop_count
);

  localparam int SEL_SPAN = 1 << SEL_BITS;

  state_t              state;
  state_t              state_nxt;
  logic [SEL_BITS-1:0] lk_sel;
  logic                lk_bc;
  logic [SEL_BITS-1:0] tsel;
  logic                tb;
  logic                sel_ok;
  logic                acc;
  logic                drop;
  logic [N_OUT-1:0]    free;
  logic [N_OUT-1:0]    load;
  logic [SEL_SPAN-1:0] free_x;

  assign tsel   = (state == ST_LOCKED) ? lk_sel : in_sel;
  assign tb     = (state == ST_LOCKED) ? lk_bc : in_bcast;
  assign sel_ok = 32'(tsel) < 32'(N_OUT);

  // Unused select codes read as free, so invalid targets are always accepted.
  always_comb begin
    free_x = '1;
    free_x[N_OUT-1:0] = free;
  end

  assign in_ready = tb ? &free : free_x[tsel];
  assign acc      = in_valid & in_ready;
  assign drop     = acc & !tb & !sel_ok;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++)
      load[k] = acc & (tb | (tsel == SEL_BITS'(k)));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (acc && !in_last) state_nxt = ST_LOCKED;
      ST_LOCKED: if (acc && in_last)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      lk_sel <= '0;
      lk_bc  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && acc && !in_last) begin
        lk_sel <= in_sel;
        lk_bc  <= in_bcast;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sel    <= 1'b0;
      drop_count <= '0;
    end else begin
      err_sel <= drop;
      if (drop && drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_out_slot #(
      .DATA_BITS(DATA_BITS)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (load[k]),
      .in_data (in_data),
      .in_last (in_last),
      .ready   (out_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*DATA_BITS +: DATA_BITS]),
      .last    (out_last[k]),
      .free    (free[k])
    );
  end

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: N_OUT=4 with a channel model,
// plus an N_OUT=3 instance for invalid-target drops.
module tb_demux_stream_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         rst, iv, ir, ib, il, es;
  logic [31:0]  id;
  logic [1:0]   is;
  logic [3:0]   ov, ordy, ol;
  logic [127:0] od;
  logic [15:0]  dc;

  logic         rst3, iv3, ir3, ib3, il3, es3;
  logic [31:0]  id3;
  logic [1:0]   is3;
  logic [2:0]   ov3, ordy3, ol3;
  logic [95:0]  od3;
  logic [15:0]  dc3;

  demux_stream_n #(.DATA_BITS(32), .N_OUT(4)) dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
    .in_data(id), .in_sel(is), .in_bcast(ib), .in_last(il),
    .out_valid(ov), .out_ready(ordy), .out_data(od),
    .out_last(ol), .err_sel(es), .drop_count(dc)
  );

  demux_stream_n #(.DATA_BITS(32), .N_OUT(3)) dut3 (
    .clk(clk), .reset(rst3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .in_sel(is3), .in_bcast(ib3), .in_last(il3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
    .out_last(ol3), .err_sel(es3), .drop_count(dc3)
  );

  // Model of the four channels: what each consumer should currently see.
  logic        mv[4];
  logic [31:0] md[4];
  logic        ml[4];
  logic        lk;
  logic [1:0]  lsel;
  logic        lbc;

  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc();
    logic [1:0]   ts;
    logic         t_b, rdy, acc;
    logic [3:0]   fr, ev, el;
    logic [127:0] ed, mask;
    #1;
    ts  = lk ? lsel : is;
    t_b = lk ? lbc : ib;
    for (int k = 0; k < 4; k++) fr[k] = !mv[k] || ordy[k];
    rdy = t_b ? (&fr) : fr[ts];
    if (!rst) chk("in_ready", {127'b0, ir}, {127'b0, rdy});
    acc = iv && rdy && !rst;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mv[k] = 1'b0; md[k] = '0; ml[k] = 1'b0;
      end
      lk = 1'b0; lsel = '0; lbc = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc && (t_b || ts == 2'(k))) begin
          mv[k] = 1'b1; md[k] = id; ml[k] = il;
        end else if (ordy[k]) begin
          mv[k] = 1'b0;
        end
      end
      if (acc && !lk && !il) begin
        lk = 1'b1; lsel = is; lbc = ib;
      end else if (acc && lk && il) begin
        lk = 1'b0;
      end
    end
    #1;
    ed = '0; mask = '0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = mv[k];
      el[k] = mv[k] & ml[k];
      ed[k*32 +: 32] = md[k];
      mask[k*32 +: 32] = {32{mv[k]}};
    end
    chk("out_valid", {124'b0, ov}, {124'b0, ev});
    chk("out_data", od & mask, ed & mask);
    chk("out_last", {124'b0, ol & ov}, {124'b0, el});
    chk("err_sel", {127'b0, es}, 128'd0);
    chk("drop_count", {112'b0, dc}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; iv = 0; ib = 0; il = 0; id = '0; is = '0; ordy = 4'hF;
    rst3 = 1'b1; iv3 = 0; ib3 = 0; il3 = 0; id3 = '0; is3 = '0;
    ordy3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0; md[k] = '0; ml[k] = 1'b0;
    end
    lk = 1'b0; lsel = '0; lbc = 1'b0;

    // N_OUT=3: select code 3 has no channel
    repeat (2) @(posedge clk);
    #1 rst3 = 1'b0;
    chk("d3_rst_valid", {125'b0, ov3}, 128'd0);
    chk("d3_rst_drops", {112'b0, dc3}, 128'd0);
    iv3 = 1; is3 = 2'd3; il3 = 0; id3 = 32'hDEAD_0001;
    #1 chk("d3_ready_inv", {127'b0, ir3}, 128'd1);
    @(posedge clk); #1;
    chk("d3_err_1", {127'b0, es3}, 128'd1);
    chk("d3_drops_1", {112'b0, dc3}, 128'd1);
    chk("d3_valid_1", {125'b0, ov3}, 128'd0);
    is3 = 2'd0; il3 = 1; id3 = 32'hDEAD_0002;
    @(posedge clk); #1;
    chk("d3_err_2", {127'b0, es3}, 128'd1);
    chk("d3_drops_2", {112'b0, dc3}, 128'd2);
    chk("d3_valid_2", {125'b0, ov3}, 128'd0);
    iv3 = 0;
    @(posedge clk); #1;
    chk("d3_err_idle", {127'b0, es3}, 128'd0);
    chk("d3_drops_idle", {112'b0, dc3}, 128'd2);
    iv3 = 1; is3 = 2'd1; il3 = 1; id3 = 32'h3333_0001;
    @(posedge clk); #1;
    iv3 = 0;
    chk("d3_valid_ch1", {125'b0, ov3}, 128'd2);
    chk("d3_data_ch1", {96'b0, od3[63:32]}, 128'h3333_0001);

    // N_OUT=4: reset, then reset mid-packet
    cyc(); cyc();
    chk("rst_valid", {124'b0, ov}, 128'd0);
    rst = 0;
    iv = 1; is = 2'd1; il = 0; id = 32'h1111_0001;
    cyc();
    id = 32'h1111_0002; rst = 1;
    cyc();
    iv = 0;
    cyc();
    chk("mid_rst_valid", {124'b0, ov}, 128'd0);
    rst = 0;
    iv = 1; is = 2'd3; il = 1; id = 32'h1111_0003;
    cyc();
    chk("post_rst_ch3", {124'b0, ov}, 128'h8);

    // unicast
    is = 2'd2; id = 32'hA5A5_0001;
    cyc();
    chk("uni_valid", {124'b0, ov}, 128'h4);
    chk("uni_data", {96'b0, od[95:64]}, 128'hA5A5_0001);

    // packet lock: select changes after the first word
    for (int i = 0; i < 3; i++) begin
      is = (i == 0) ? 2'd1 : 2'd3;
      il = (i == 2);
      id = 32'h2222_0000 + 32'(i);
      cyc();
      chk("lock_valid", {124'b0, ov}, 128'h2);
      chk("lock_last", {127'b0, ol[1]}, {127'b0, il});
    end
    iv = 0;
    cyc();

    // back-pressure on channel 0
    ordy = 4'b1110; iv = 1; is = 2'd0; il = 1; id = 32'hB0B0_0000;
    cyc();
    id = 32'hB0B0_0001;
    #1 chk("bp_ready", {127'b0, ir}, 128'd0);
    cyc();
    chk("bp_hold", {96'b0, od[31:0]}, 128'hB0B0_0000);
    ordy = 4'hF;
    cyc();
    chk("bp_reload", {96'b0, od[31:0]}, 128'hB0B0_0001);

    // broadcast stalled by channel 2
    ordy = 4'b1011; is = 2'd2; id = 32'hC0C0_0000;
    cyc();
    ib = 1; id = 32'hC0C0_0001;
    #1 chk("bc_stall", {127'b0, ir}, 128'd0);
    cyc();
    ordy = 4'hF;
    cyc();
    chk("bc_valid", {124'b0, ov}, 128'hF);
    chk("bc_data", od, {4{32'hC0C0_0001}});
    iv = 0; ib = 0;
    cyc();

    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      iv   = 1'($urandom);
      is   = 2'($urandom);
      ib   = ($urandom_range(0, 4) == 0);
      il   = ($urandom_range(0, 2) == 0);
      id   = $urandom;
      ordy = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
